// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder, one bit pair per clock through a single full adder, LSB first.
// Latency WIDTH+1 cycles from accepted start to done; start is ignored while busy, S/C held until next result.
module serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] S,
    output logic             C
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic             load;
    logic             step;
    logic             last;
    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic             carry_q;
    logic [CW-1:0]    cnt;
    logic             s_bit;
    logic             c_bit;
    logic [WIDTH-1:0] sum_nxt;

    F_A u_fa (
        .a  (a_sr[0]),
        .b  (b_sr[0]),
        .ci (carry_q),
        .s  (s_bit),
        .co (c_bit)
    );

    assign last = (cnt == CW'(WIDTH - 1));
    assign busy = (state == RUN);
    assign done = (state == DONE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        step      = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    load      = 1'b1;
                    state_nxt = RUN;
                end
            end
            RUN: begin
                step = 1'b1;
                if (last) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                // back-to-back accept keeps throughput at one add per WIDTH+1 cycles
                if (start) begin
                    load      = 1'b1;
                    state_nxt = RUN;
                end else begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Sum shift register holds the WIDTH-1 bits already produced; the final
    // sum is those bits plus the bit coming out of the adder this cycle.
    generate
        if (WIDTH == 1) begin : g_w1
            assign sum_nxt = s_bit;
        end else begin : g_wn
            logic [WIDTH-2:0] sum_sr;

            assign sum_nxt = {s_bit, sum_sr};

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    sum_sr <= '0;
                end else if (load) begin
                    sum_sr <= '0;
                end else if (step) begin
                    sum_sr <= sum_nxt[WIDTH-1:1];
                end
            end
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_sr    <= '0;
            b_sr    <= '0;
            carry_q <= 1'b0;
            cnt     <= '0;
            S       <= '0;
            C       <= 1'b0;
        end else if (load) begin
            a_sr    <= a;
            b_sr    <= b;
            carry_q <= c_in;
            cnt     <= '0;
        end else if (step) begin
            a_sr    <= a_sr >> 1;
            b_sr    <= b_sr >> 1;
            carry_q <= c_bit;
            cnt     <= cnt + CW'(1);
            if (last) begin
                S <= sum_nxt;
                C <= c_bit;
            end
        end
    end

endmodule

// One-bit full adder used as the serial adder's only arithmetic element.
module F_A (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);

    assign s  = a ^ b ^ ci;
    assign co = (a & b) | (ci & (a ^ b));

endmodule
